// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encoding and arithmetic helpers for the keypad entry block.
package keypad_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Debouncer phases and entry phases share one encoding; ST_IDLE doubles as
    // "accepting keys" on the entry side.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT,
        ST_CONVERT,
        ST_VALID
    } state_t;

    function automatic logic is_idle_code(input logic [3:0] c);
        return c >= 4'd12;
    endfunction

    function automatic logic [31:0] mul10(input logic [31:0] a);
        return (a << 3) + (a << 1);
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Scanner/processor-facing signals of keypad_entry; slave is the block, master the environment.
interface keypad_entry_if #(parameter int MAX_DIGITS = 6);
    logic [3:0]              key_code;
    logic [31:0]             key_ack;
    logic [4*MAX_DIGITS-1:0] digits_bcd;
    logic [3:0]              digit_count;
    logic [31:0]             value;
    logic                    entry_valid;
    logic                    entry_ack;
    logic                    busy;

    modport master (
        output key_code, entry_ack,
        input  key_ack, digits_bcd, digit_count, value, entry_valid, busy
    );

    modport slave (
        input  key_code, entry_ack,
        output key_ack, digits_bcd, digit_count, value, entry_valid, busy
    );
endinterface

// File: rtl/key_debouncer.sv
// Press/release qualification: a code must be seen STABLE_CYCLES times in a row to count.
// press_o is a registered one-cycle strobe; code_o holds the qualified code.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code_i,
    input  logic       freeze_i,
    input  logic       resync_i,
    output logic       press_o,
    output logic [3:0] code_o
);
    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    code_q;
    logic          press_q;
    logic          key_idle;

    assign key_idle = is_idle_code(key_code_i);
    assign press_o  = press_q;
    assign code_o   = code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            // Leaving a completed entry: a still-held key must be released before it counts again.
            if (resync_i) begin
                state_q <= key_idle ? ST_IDLE : ST_HELD;
                cnt_q   <= '0;
            end else if (!freeze_i) begin
                case (state_q)
                    ST_IDLE: if (!key_idle) begin
                        code_q <= key_code_i;
                        if (ONE == STABLE_C) begin
                            press_q <= 1'b1;
                            state_q <= ST_HELD;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_PRESS_WAIT;
                            cnt_q   <= ONE;
                        end
                    end
                    ST_PRESS_WAIT: if (key_code_i == code_q) begin
                        if (cnt_q + ONE == STABLE_C) begin
                            press_q <= 1'b1;
                            state_q <= ST_HELD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                    ST_HELD: if (key_idle) begin
                        if (ONE == STABLE_C) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_RELEASE_WAIT;
                            cnt_q   <= ONE;
                        end
                    end
                    ST_RELEASE_WAIT: if (!key_idle) begin
                        state_q <= ST_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q + ONE == STABLE_C) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad numeric entry: BCD digit collection, '*' clear/backspace, '#' enter with BCD->binary.
// Define KEYPAD_ENTRY_BACKSPACE_EN to make '*' a backspace instead of a full clear.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS    = 6,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic          clock,
    input  logic          reset_n,
    keypad_entry_if.slave bus
);
    localparam int         DW    = BCD_W * MAX_DIGITS;
    localparam logic [3:0] MAX_C = 4'(MAX_DIGITS);

    state_t           state_q;
    logic [DW-1:0]    digits_q;
    logic [3:0]       count_q;
    logic [3:0]       idx_q;
    logic [31:0]      acc_q;
    logic [31:0]      value_q;
    logic             valid_q;
    logic             busy_q;
    logic             ack_q;
    logic             press;
    logic [3:0]       code;
    logic             resync;
    logic [BCD_W-1:0] cur_digit;

    assign resync = (state_q == ST_VALID) && bus.entry_ack;

    key_debouncer #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb (
        .clk        (clock),
        .rst_n      (reset_n),
        .key_code_i (bus.key_code),
        .freeze_i   (busy_q),
        .resync_i   (resync),
        .press_o    (press),
        .code_o     (code)
    );

    // idx_q counts down from digit_count; digit idx_q-1 is the next most significant.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (idx_q == 4'(i + 1)) cur_digit = digits_q[i*BCD_W +: BCD_W];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= (state_q == ST_IDLE) && press;
            case (state_q)
                ST_IDLE: if (press) begin
                    case (code)
                        KEY_HASH: if (count_q != 4'd0) begin
                            state_q <= ST_CONVERT;
                            busy_q  <= 1'b1;
                            acc_q   <= '0;
                            idx_q   <= count_q;
                        end
                        KEY_STAR: begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                            if (count_q != 4'd0) begin
                                digits_q <= digits_q >> BCD_W;
                                count_q  <= count_q - 4'd1;
                            end
`else
                            digits_q <= '0;
                            count_q  <= '0;
`endif
                        end
                        default: if (count_q < MAX_C) begin
                            digits_q <= (digits_q << BCD_W) | DW'(code);
                            count_q  <= count_q + 4'd1;
                        end
                    endcase
                end
                ST_CONVERT: if (idx_q != 4'd0) begin
                    acc_q <= mul10(acc_q) + 32'(cur_digit);
                    idx_q <= idx_q - 4'd1;
                end else begin
                    value_q <= acc_q;
                    valid_q <= 1'b1;
                    state_q <= ST_VALID;
                end
                ST_VALID: if (bus.entry_ack) begin
                    digits_q <= '0;
                    count_q  <= '0;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.key_ack     = {31'd0, ack_q};
    assign bus.digits_bcd  = digits_q;
    assign bus.digit_count = count_q;
    assign bus.value       = value_q;
    assign bus.entry_valid = valid_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: directed scenarios plus random key traffic against a sample-level model.
module tb_keypad_entry;
    localparam int MAXD = 6;
    localparam int S    = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    keypad_entry_if #(.MAX_DIGITS(MAXD)) bus ();

    keypad_entry #(.MAX_DIGITS(MAXD), .STABLE_CYCLES(S)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: digits as a queue (oldest first), key qualification as run lengths of samples.
    int          m_q[$];
    bit          m_ack, m_busy, m_valid, m_pend, m_armed;
    int          m_run, m_rrun, m_cand, m_pcode, m_left;
    longint      m_conv, m_value;
    int          cyc = 0;

    function automatic logic [4*MAXD-1:0] m_digits();
        logic [4*MAXD-1:0] d = '0;
        for (int i = 0; i < m_q.size(); i++) d[4*i +: 4] = 4'(m_q[m_q.size()-1-i]);
        return d;
    endfunction

    function automatic void m_action(input int c);
        if (c < 10) begin
            if (m_q.size() < MAXD) m_q.push_back(c);
        end else if (c == 10) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
            if (m_q.size() > 0) void'(m_q.pop_back());
`else
            m_q.delete();
`endif
        end else if (m_q.size() > 0) begin
            m_busy = 1;
            m_left = m_q.size();
            m_conv = 0;
            foreach (m_q[i]) m_conv = m_conv * 10 + m_q[i];
        end
    endfunction

    function automatic void m_sample(input int c);
        m_pend = 0;
        if (m_armed) begin
            if (c >= 12 || (m_run > 0 && c != m_cand)) m_run = 0;
            else begin
                if (m_run == 0) m_cand = c;
                m_run++;
                if (m_run == S) begin
                    m_pend = 1; m_pcode = m_cand; m_armed = 0; m_run = 0; m_rrun = 0;
                end
            end
        end else if (c >= 12) begin
            m_rrun++;
            if (m_rrun == S) begin m_armed = 1; m_rrun = 0; end
        end else m_rrun = 0;
    endfunction

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_q.delete(); m_ack = 0; m_busy = 0; m_valid = 0; m_pend = 0; m_armed = 1;
            m_run = 0; m_rrun = 0; m_cand = 0; m_pcode = 0; m_left = 0; m_conv = 0; m_value = 0;
        end else begin
            bit ob, ov, op;
            int c;
            cyc++;
            ob = m_busy; ov = m_valid; op = m_pend; c = int'(bus.key_code);
            m_ack = op && !ob;
            if (op && !ob) m_action(m_pcode);
            if (ob && !ov) begin
                if (m_left > 0) m_left--;
                else begin m_valid = 1; m_value = m_conv; end
            end
            if (ov && bus.entry_ack) begin
                m_q.delete(); m_valid = 0; m_busy = 0;
                m_armed = (c >= 12); m_run = 0; m_rrun = 0; m_pend = 0;
            end else if (!ob) m_sample(c);
            else m_pend = 0;
        end
    end

    int n_acks = 0, last_ack_cyc = 0, valid_cyc = 0;
    bit prev_valid = 0;

    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            if (bus.key_ack[0]) begin n_acks++; last_ack_cyc = cyc; end
            if (bus.entry_valid && !prev_valid) valid_cyc = cyc;
            check("key_ack", 64'(bus.key_ack), {63'd0, m_ack});
            check("digits_bcd", 64'(bus.digits_bcd), 64'(m_digits()));
            check("digit_count", 64'(bus.digit_count), 64'(m_q.size()));
            check("entry_valid", 64'(bus.entry_valid), 64'(m_valid));
            check("busy", 64'(bus.busy), 64'(m_busy));
            if (m_valid) check("value", 64'(bus.value), 64'(m_value));
        end
        prev_valid = bus.entry_valid;
    end

    task automatic drive(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) begin @(posedge clock); #1 bus.key_code = c; end
    endtask

    task automatic release_key(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1 bus.key_code = 4'(12 + $urandom_range(0, 3));
        end
    endtask

    task automatic press(input int c);
        drive(4'(c), 10);
        release_key(10);
    endtask

    task automatic ack_entry();
        @(posedge clock); #1 bus.entry_ack = 1'b1;
        @(posedge clock); #1 bus.entry_ack = 1'b0;
    endtask

    int a0;

    initial begin
        bus.key_code = 4'd12; bus.entry_ack = 1'b0; reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_digits", 64'(bus.digits_bcd), 64'd0);
        check("rst_count", 64'(bus.digit_count), 64'd0);
        check("rst_key_ack", 64'(bus.key_ack), 64'd0);
        check("rst_value", 64'(bus.value), 64'd0);
        check("rst_valid_busy", {62'd0, bus.entry_valid, bus.busy}, 64'd0);
        reset_n = 1'b1;

        a0 = n_acks;
        press(1); press(2); press(3); press(11);
        check("s1_value", 64'(bus.value), 64'd123);
        check("s1_count", 64'(bus.digit_count), 64'd3);
        check("s1_valid", 64'(bus.entry_valid), 64'd1);
        check("s1_acks", 64'(n_acks - a0), 64'd4);
        check("s1_latency", 64'(valid_cyc - last_ack_cyc), 64'd4);
        ack_entry();
        release_key(3);
        check("s1_cleared", {59'd0, bus.entry_valid, bus.digit_count}, 64'd0);

        a0 = n_acks;
        drive(4'd5, 2);
        release_key(10);
        check("s2_acks", 64'(n_acks - a0), 64'd0);
        check("s2_digits", 64'(bus.digits_bcd), 64'd0);

        a0 = n_acks;
        for (int i = 0; i < 9; i++) press(9);
        check("s3_count", 64'(bus.digit_count), 64'd6);
        press(11);
        check("s3_value", 64'(bus.value), 64'd999999);
        check("s3_acks", 64'(n_acks - a0), 64'd10);
        ack_entry();

        a0 = n_acks;
        press(4); press(7); press(10); press(11);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
        check("s4_valid", 64'(bus.entry_valid), 64'd1);
        check("s4_value", 64'(bus.value), 64'd4);
        ack_entry();
`else
        check("s4_valid", 64'(bus.entry_valid), 64'd0);
        check("s4_count", 64'(bus.digit_count), 64'd0);
        check("s4_busy", 64'(bus.busy), 64'd0);
`endif
        check("s4_acks", 64'(n_acks - a0), 64'd4);

        press(6); press(11);
        a0 = n_acks;
        drive(4'd8, 10);
        check("s5_no_ack_busy", 64'(n_acks - a0), 64'd0);
        ack_entry();
        drive(4'd8, 10);
        check("s5_held_count", 64'(bus.digit_count), 64'd0);
        check("s5_held_acks", 64'(n_acks - a0), 64'd0);
        release_key(10);
        press(8);
        check("s5_repress", 64'(bus.digits_bcd), 64'h8);
        check("s5_repress_acks", 64'(n_acks - a0), 64'd1);
        press(10);

        press(9); press(8); press(7);
        drive(4'd11, 1);
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clock);
        check("s6_busy", 64'(bus.busy), 64'd1);
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        check("s6_rst_outputs", {bus.digits_bcd, bus.digit_count, bus.entry_valid, bus.busy, bus.key_ack[0]}, 64'd0);
        check("s6_rst_value", 64'(bus.value), 64'd0);
        bus.key_code = 4'd12;
        @(posedge clock); #1 reset_n = 1'b1;
        press(5); press(11);
        check("s6_value", 64'(bus.value), 64'd5);
        check("s6_valid", 64'(bus.entry_valid), 64'd1);
        ack_entry();

        for (int seg = 0; seg < 300; seg++) begin
            int len = $urandom_range(1, 8);
            logic [3:0] c = ($urandom_range(0, 3) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                         : 4'($urandom_range(0, 11));
            for (int i = 0; i < len; i++) begin
                @(posedge clock); #1;
                bus.key_code  = c;
                bus.entry_ack = ($urandom_range(0, 5) == 0);
            end
        end
        bus.entry_ack = 1'b0;
        release_key(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
